// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single memory port: cpu on port 0, loader on port 1.
// Define ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
module mem_port_arbiter #(
   parameter int AW     = 9,
   parameter int DW     = 16,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic [1:0]    mem_cmd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] write_data,
   input  logic [DW-1:0] read_data
);

   localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          win;
   logic          weL;
   logic          lastGrant;
   logic          pick;
   logic          pickWe;

   // Winner selection; only the contention case depends on the arbitration mode.
   always_comb begin
      pick = lastGrant;
      if (req0 && req1) begin
`ifdef ARB_RR_EN
         pick = ~lastGrant;
`else
         pick = 1'b0;
`endif
      end else if (req0) begin
         pick = 1'b0;
      end else if (req1) begin
         pick = 1'b1;
      end
      pickWe = pick ? we1 : we0;
   end

   // The memory command is loaded on entry to ISSUE and held unchanged for RD_LAT cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         win        <= 1'b0;
         weL        <= 1'b0;
         lastGrant  <= 1'b1;
         mem_cmd    <= MNONE;
         mem_addr   <= '0;
         write_data <= '0;
         rdata      <= '0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  win        <= pick;
                  weL        <= pickWe;
                  mem_cmd    <= pickWe ? MWRITE : MREAD;
                  mem_addr   <= pick ? addr1 : addr0;
                  write_data <= pick ? wdata1 : wdata0;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end else begin
                  mem_cmd <= MNONE;
               end
            end
            ISSUE: begin
               if (cnt == CNT_LAST) begin
                  if (!weL) begin
                     rdata <= read_data;
                  end
                  mem_cmd <= MNONE;
                  ack0    <= ~win;
                  ack1    <= win;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               ack0      <= 1'b0;
               ack1      <= 1'b0;
               busy      <= 1'b0;
               lastGrant <= win;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
